// File: rtl/yolo_pool_stream.sv
// Streaming KxK / stride-S max-pooling engine over a raster-order WxW map, CHANNELS lanes wide.
// Define YOLO_POOL_AVG_EN to add a pool_mode input and per-frame average pooling.

module yolo_pool_lane #(
  parameter int DW = 8,
  parameter int K  = 2,
  parameter int N  = K*K
) (
`ifdef YOLO_POOL_AVG_EN
  input  logic                  mode_i,
`endif
  input  logic [N-1:0][DW-1:0]  win_i,
  output logic [DW-1:0]         res_o
);
  logic signed [DW-1:0] mx;

  always_comb begin
    mx = win_i[0];
    for (int i = 1; i < N; i++)
      if ($signed(win_i[i]) > mx) mx = win_i[i];
  end

`ifdef YOLO_POOL_AVG_EN
  localparam int SH = 2*$clog2(K);
  localparam int AW = DW + SH;

  if ((1 << $clog2(K)) != K) begin : g_bad_k
    $error("yolo_pool_lane: average mode needs a power-of-two window");
  end

  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shf;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + AW'($signed(win_i[i]));
    // arithmetic shift gives floor division, so -3/4 -> -1
    shf = sum >>> SH;
  end

  assign res_o = mode_i ? shf[DW-1:0] : mx;
`else
  assign res_o = mx;
`endif
endmodule

module yolo_pool_stream #(
  parameter int DATA_WIDTH       = 8,
  parameter int ARRAY_WIDTH      = 3,
  parameter int POOL_FILTER_SIZE = 2,
  parameter int POOL_STRIDE      = 1,
  parameter int CHANNELS         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef YOLO_POOL_AVG_EN
  input  logic                           pool_mode,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           frame_done
);
  localparam int RESULT_WIDTH = ((ARRAY_WIDTH-POOL_FILTER_SIZE)/POOL_STRIDE)+1;
  localparam int W    = ARRAY_WIDTH;
  localparam int K    = POOL_FILTER_SIZE;
  localparam int S    = POOL_STRIDE;
  localparam int C    = CHANNELS;
  localparam int DW   = DATA_WIDTH;
  localparam int KK   = K*K;
  localparam int CW   = (W > 1) ? $clog2(W) : 1;
  localparam int LAST = (RESULT_WIDTH-1)*S + K-1;

  function automatic logic on_grid(input logic [CW-1:0] p);
    int q;
    q = int'(p) - (K-1);
    return (q >= 0) && ((q % S) == 0);
  endfunction

  logic [C-1:0][DW-1:0]       smp;
  logic [KK-1:0][C-1:0][DW-1:0] wnd;
  logic [C-1:0][DW-1:0]       res;
  logic [CW-1:0]              col_q, col_d, row_q, row_d;
  logic [C-1:0][DW-1:0]       out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       last_q, last_d;
  logic                       acc, fire, is_last;

  assign smp      = in_data;
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign fire     = acc && on_grid(row_q) && on_grid(col_q);
  assign is_last  = (row_q == CW'(LAST)) && (col_q == CW'(LAST));

  // Line buffers hold the previous K-1 rows by column; window registers hold
  // the previous K-1 columns of the current vertical slice.
  if (K == 1) begin : g_k1
    assign wnd[0] = smp;
  end else begin : g_kn
    logic [K-2:0][W-1:0][C-1:0][DW-1:0] lb_q;
    logic [K-1:0][K-2:0][C-1:0][DW-1:0] win_q;
    logic [K-1:0][C-1:0][DW-1:0]        colv;

    always_comb begin
      colv[0] = smp;
      for (int j = 1; j < K; j++) colv[j] = lb_q[j-1][col_q];
    end

    always_comb begin
      wnd = '0;
      for (int j = 0; j < K; j++) begin
        wnd[j*K] = colv[j];
        for (int k = 1; k < K; k++) wnd[j*K+k] = win_q[j][k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lb_q  <= '0;
        win_q <= '0;
      end else if (acc) begin
        for (int j = 0; j < K-1; j++) lb_q[j][col_q] <= colv[j];
        for (int j = 0; j < K; j++) begin
          win_q[j][0] <= colv[j];
          for (int k = 1; k < K-1; k++) win_q[j][k] <= win_q[j][k-1];
        end
      end
    end
  end

`ifdef YOLO_POOL_AVG_EN
  logic mode_q, mode_eff;
  // the first pixel of a frame already uses the freshly sampled mode
  assign mode_eff = (row_q == '0 && col_q == '0) ? pool_mode : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      mode_q <= 1'b0;
    else if (acc && row_q == '0 && col_q == '0)   mode_q <= pool_mode;
  end
`endif

  for (genvar c = 0; c < C; c++) begin : g_lane
    logic [KK-1:0][DW-1:0] lw;
    always_comb
      for (int i = 0; i < KK; i++) lw[i] = wnd[i][c];

    yolo_pool_lane #(.DW(DW), .K(K), .N(KK)) u_lane (
`ifdef YOLO_POOL_AVG_EN
      .mode_i (mode_eff),
`endif
      .win_i  (lw),
      .res_o  (res[c])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_q == CW'(W-1)) begin
        col_d = '0;
        row_d = (row_q == CW'(W-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = fire || (out_valid_q && !out_ready);
    out_data_d  = fire ? res : out_data_q;
    last_d      = fire ? is_last : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q && out_ready && last_q;
endmodule
